nibble_serial_add_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 4-bit ripple adder slice, one nibble per clock, LSB nibble first.
- Latches operands on a start pulse and drives the slice operand and carry-in ports.
- Captures the slice sum and carry-out into a result register, then pulses done.
- Used wherever a wide add is needed but only one 4-bit adder slice is available in the datapath.

---
 rtl/nibble_serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Wide unsigned adder sequencer: reuses one external 4-bit slice, one nibble per clock, LSB first.
// Accept edge k, RUN k+1..k+NIB, done pulse in k+NIB+1; start is ignored while busy (no queuing).
module nibble_serial_add_ctrl #(
   parameter  int WIDTH = 16,
   localparam int NIB   = WIDTH / 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [3:0]       slice_a,
   output logic [3:0]       slice_b,
   output logic             slice_cin,
   input  logic [3:0]       slice_s,
   input  logic             slice_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             accept;
   logic             last;

   // Current nibble selected by shifting, so the slice index stays a plain constant range.
   assign a_shift = a_reg >> {idx, 2'b00};
   assign b_shift = b_reg >> {idx, 2'b00};
   assign last    = (idx == IDX_LAST);

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      slice_a   = 4'h0;
      slice_b   = 4'h0;
      slice_cin = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            slice_a   = a_shift[3:0];
            slice_b   = b_shift[3:0];
            slice_cin = carry;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_reg <= '0;
         b_reg <= '0;
         idx   <= '0;
         carry <= 1'b0;
         s     <= '0;
         c_out <= 1'b0;
      end else if (accept) begin
         a_reg <= a;
         b_reg <= b;
         carry <= c_in;
         idx   <= '0;
         s     <= '0;
      end else if (state == RUN) begin
         for (int n = 0; n < NIB; n++) begin
            if (idx == IW'(n)) begin
               s[4*n +: 4] <= slice_s;
            end
         end
         // Carry is strictly rippled through this register between nibbles.
         carry <= slice_cout;
         if (last) begin
            idx   <= '0;
            c_out <= slice_cout;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule
